// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

  // Operand classification; subnormals are folded into ZERO.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Flag vector layout {NV, OF, UF}.
  localparam int FLAG_W  = 3;
  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only mantissa MSB set.
  // Returned in a wide word; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand and the result side.
interface fp_mul_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_result;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even a normalised mantissa and pack sign/exponent/mantissa.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [MAN_W-1:0]       mant,
  input  logic                   guard,
  input  logic                   sticky,
  input  logic [EXP_W+1:0]       exp_in,
  output logic [EXP_W+MAN_W:0]   word,
  output logic                   of,
  output logic                   uf
);
  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] EMAX = E_W'((1 << EXP_W) - 1);

  logic             inc;
  logic             carry;
  logic [MAN_W-1:0] mant_r;
  logic [E_W-1:0]   exp_r;

  // Round, renormalise on carry-out, then saturate to infinity or flush to zero.
  always_comb begin
    inc             = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    exp_r           = exp_in + {{(E_W-1){1'b0}}, carry};
    of              = 1'b0;
    uf              = 1'b0;
    word            = {sign, exp_r[EXP_W-1:0], mant_r};
    if ($signed(exp_r) >= EMAX) begin
      of   = 1'b1;
      word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r[E_W-1] || (exp_r == '0)) begin
      uf   = 1'b1;
      word = {sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, multiply, round/pack.
// Latency: 3 cycles from operand handshake to out_valid; one result per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready = ~stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          reset,
  fp_mul_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int BIAS   = fp_bias(EXP_W);
  localparam logic [63:0]  NAN64     = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] CANON_NAN = NAN64[W-1:0];

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)     return ZERO;
    else if (&e)     return (m == '0) ? INF : NAN;
    else             return NORM;
  endfunction

  logic stall;
  logic out_vld_q;

  assign stall        = out_vld_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // ---------------- S1: unpack / classify ----------------
  logic             s1_vld, s1_sign;
  fp_class_e        s1_cls_a, s1_cls_b;
  logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
  logic [SIG_W-1:0] s1_sig_a, s1_sig_b;

  // ---------------- S2: product / exponent sum ----------------
  logic              s2_vld, s2_sign;
  fp_class_e         s2_cls, cls_c;
  logic [PROD_W-1:0] s2_prod, prod_c;
  logic [E_W-1:0]    s2_esum, esum_c;

  // Combine operand classes into the result class; NaN dominates, 0*inf is NaN.
  always_comb begin
    cls_c = NORM;
    if (s1_cls_a == NAN || s1_cls_b == NAN)
      cls_c = NAN;
    else if ((s1_cls_a == INF && s1_cls_b == ZERO) || (s1_cls_a == ZERO && s1_cls_b == INF))
      cls_c = NAN;
    else if (s1_cls_a == INF || s1_cls_b == INF)
      cls_c = INF;
    else if (s1_cls_a == ZERO || s1_cls_b == ZERO)
      cls_c = ZERO;
  end

  assign prod_c = {{SIG_W{1'b0}}, s1_sig_a} * {{SIG_W{1'b0}}, s1_sig_b};
  assign esum_c = {2'b00, s1_exp_a} + {2'b00, s1_exp_b} - E_W'(BIAS);

  // ---------------- S3: normalise / round / pack ----------------
  logic              norm, guard, sticky;
  logic [MAN_W-1:0]  mant_n;
  logic [E_W-1:0]    exp_n;
  logic [W-1:0]      rp_word, res_nxt, out_result_q;
  logic              rp_of, rp_uf;
  logic [FLAG_W-1:0] flg_nxt, out_flags_q;

  // The product of two [1,2) significands lies in [1,4); its MSB picks the shift.
  always_comb begin
    norm   = s2_prod[PROD_W-1];
    mant_n = norm ? s2_prod[PROD_W-2 -: MAN_W] : s2_prod[PROD_W-3 -: MAN_W];
    guard  = norm ? s2_prod[MAN_W] : s2_prod[MAN_W-1];
    sticky = norm ? (|s2_prod[MAN_W-1:0]) : (|s2_prod[MAN_W-2:0]);
    exp_n  = s2_esum + {{(E_W-1){1'b0}}, norm};
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (s2_sign),
    .mant   (mant_n),
    .guard  (guard),
    .sticky (sticky),
    .exp_in (exp_n),
    .word   (rp_word),
    .of     (rp_of),
    .uf     (rp_uf)
  );

  // Special classes bypass the rounder with fixed encodings.
  always_comb begin
    res_nxt          = rp_word;
    flg_nxt          = '0;
    flg_nxt[FLAG_OF] = rp_of;
    flg_nxt[FLAG_UF] = rp_uf;
    case (s2_cls)
      NAN: begin
        res_nxt          = CANON_NAN;
        flg_nxt          = '0;
        flg_nxt[FLAG_NV] = 1'b1;
      end
      INF: begin
        res_nxt = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg_nxt = '0;
      end
      ZERO: begin
        res_nxt = {s2_sign, {(W-1){1'b0}}};
        flg_nxt = '0;
      end
      default: ;
    endcase
  end

  // Valid bits advance together and hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (!stall) begin
      s1_vld    <= bus.in_valid;
      s2_vld    <= s1_vld;
      out_vld_q <= s2_vld;
    end
  end

  // Stage data registers; contents behind a cleared valid bit are don't-care.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign  <= bus.in_a[W-1] ^ bus.in_b[W-1];
      s1_cls_a <= classify(bus.in_a[W-2 -: EXP_W], bus.in_a[MAN_W-1:0]);
      s1_cls_b <= classify(bus.in_b[W-2 -: EXP_W], bus.in_b[MAN_W-1:0]);
      s1_exp_a <= bus.in_a[W-2 -: EXP_W];
      s1_exp_b <= bus.in_b[W-2 -: EXP_W];
      s1_sig_a <= {1'b1, bus.in_a[MAN_W-1:0]};
      s1_sig_b <= {1'b1, bus.in_b[MAN_W-1:0]};
      s2_sign  <= s1_sign;
      s2_cls   <= cls_c;
      s2_prod  <= prod_c;
      s2_esum  <= esum_c;
    end
  end

  // Output register: cleared by reset, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (!stall) begin
      out_result_q <= res_nxt;
      out_flags_q  <= flg_nxt;
    end
  end

  assign bus.out_valid  = out_vld_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (binary32 configuration).
// Latency: checks the 3-cycle operand-to-result delay.
// Backpressure: exercises a 4-cycle out_ready drop mid-stream.
module tb_fp_mul_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Present one operand pair, then count negedges until out_valid (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [2:0] flg, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = bus.out_result;
    flg = bus.out_flags;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL reset out_result: got %h want 00000000", bus.out_result); end
    total++; if (bus.out_flags !== 3'b000) begin bad++; $display("FAIL reset out_flags: got %b want 000", bus.out_flags); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    vec_t v [3];
    logic [31:0] res; logic [2:0] flg; int lat;
    v = '{'{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000},
          '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000},
          '{32'hBFC00000, 32'hC0000000, 32'h40400000, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].a, v[i].b, res, flg, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL basic[%0d] latency: got %0d want 3", i, lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL basic[%0d] result: got %h want %h", i, res, v[i].r); end
      total++; if (flg !== v[i].f) begin bad++; $display("FAIL basic[%0d] flags: got %b want %b", i, flg, v[i].f); end
    end
  endtask

  task automatic test_rounding();
    vec_t v [3];
    logic [31:0] res; logic [2:0] flg; int lat;
    v = '{'{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000},
          '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000},
          '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].a, v[i].b, res, flg, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL round[%0d] latency: got %0d want 3", i, lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL round[%0d] result: got %h want %h", i, res, v[i].r); end
      total++; if (flg !== v[i].f) begin bad++; $display("FAIL round[%0d] flags: got %b want %b", i, flg, v[i].f); end
    end
  endtask

  task automatic test_range();
    vec_t v [6];
    logic [31:0] res; logic [2:0] flg; int lat;
    v = '{'{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010},
          '{32'hFF000000, 32'h7F000000, 32'hFF800000, 3'b010},
          '{32'h7F000000, 32'h3FC00000, 32'h7F400000, 3'b000},
          '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001},
          '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001},
          '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].a, v[i].b, res, flg, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL range[%0d] latency: got %0d want 3", i, lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL range[%0d] result: got %h want %h", i, res, v[i].r); end
      total++; if (flg !== v[i].f) begin bad++; $display("FAIL range[%0d] flags: got %b want %b", i, flg, v[i].f); end
    end
  endtask

  task automatic test_special();
    vec_t v [7];
    logic [31:0] res; logic [2:0] flg; int lat;
    v = '{'{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100},
          '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000},
          '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100},
          '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000},
          '{32'h00000001, 32'h40000000, 32'h00000000, 3'b000},
          '{32'hFF800000, 32'h80000000, 32'h7FC00000, 3'b100},
          '{32'h00000001, 32'h7F800000, 32'h7FC00000, 3'b100}};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].a, v[i].b, res, flg, lat);
      total++; if (res !== v[i].r) begin bad++; $display("FAIL special[%0d] result: got %h want %h", i, res, v[i].r); end
      total++; if (flg !== v[i].f) begin bad++; $display("FAIL special[%0d] flags: got %b want %b", i, flg, v[i].f); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] src [8];
    logic [31:0] exp_r [8];
    logic [31:0] held;
    logic        held_v;
    int sent, got, cyc, stall_cnt, extra;
    src   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    exp_r = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    sent = 0; got = 0; cyc = 0; stall_cnt = 0; extra = 0; held = '0; held_v = 1'b0;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 6 && cyc < 10);
      bus.in_valid  = (sent < 8);
      bus.in_a      = (sent < 8) ? src[sent] : 32'h0;
      bus.in_b      = 32'h40000000;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall_cnt++;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b in_ready during stall cyc %0d: got %b want 0", cyc, bus.in_ready); end
        if (held_v) begin
          total++; if (bus.out_result !== held) begin bad++; $display("FAIL b2b held result cyc %0d: got %h want %h", cyc, bus.out_result, held); end
        end
        held   = bus.out_result;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        total++; if (bus.out_result !== exp_r[got]) begin bad++; $display("FAIL b2b result[%0d]: got %h want %h", got, bus.out_result, exp_r[got]); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (got !== 8) begin bad++; $display("FAIL b2b result count: got %0d want 8", got); end
    total++; if (stall_cnt !== 4) begin bad++; $display("FAIL b2b stall cycles: got %0d want 4", stall_cnt); end
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b extra results: got %0d want 0", extra); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] ops [3];
    int stale;
    ops = '{32'h3FC00000, 32'h40400000, 32'h40800000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = ops[i];
      bus.in_b      = 32'h40000000;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL inflight out_valid after reset: got %b want 0", bus.out_valid); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL inflight out_result after reset: got %h want 00000000", bus.out_result); end
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL inflight in_ready after reset: got %b want 1", bus.in_ready); end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL inflight stale results: got %0d want 0", stale); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
